blink_scheduler: RTL and testbench

BLINK_SCHEDULER -- requirements
Module: blink_scheduler

---
 rtl/blink_pkg.sv | 30 +++
 rtl/blink_tick_gen.sv | 23 ++
 rtl/blink_scheduler.sv | 124 ++++++++++++
 tb/tb_blink_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants for the blink scheduler: lamp patterns, side encoding, FSM states.
// The HAZ state exists only when BLINK_HAZARD_EN is defined.
package blink_pkg;

  localparam logic [2:0] P0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b011;
  localparam logic [2:0] P3 = 3'b111;

  localparam logic SIDE_RIGHT = 1'b0;
  localparam logic SIDE_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_L = 2'd1,
    RUN_R = 2'd2
`ifdef BLINK_HAZARD_EN
    , HAZ = 2'd3
`endif
  } state_t;

  function automatic logic [2:0] next_pattern(input logic [2:0] p);
    case (p)
      P1:      next_pattern = P2;
      P2:      next_pattern = P3;
      default: next_pattern = P0;
    endcase
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running divider: tick is high for one cycle while count == TICK_DIV-1.
module blink_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [7:0] count;

  assign tick = (count == 8'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + 8'd1;
  end

endmodule

// File: rtl/blink_scheduler.sv
// Turn-signal scheduler: round-robin left/right blink sequences paced by a tick.
// Optional hazard mode compiled in with BLINK_HAZARD_EN.
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_hazard,
  output logic [2:0] lights_l,
  output logic [2:0] lights_r,
  output logic       busy,
  output logic       last_side
);

  logic   tick;
  state_t state, state_n;
  logic [2:0] ll_n, lr_n;
  logic   last_n;
  logic   pend_l, pend_r;
  logic   again_l, again_r;
  logic   done_l, done_r;

  blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifndef BLINK_HAZARD_EN
  logic unused_hazard;
  assign unused_hazard = req_hazard;
`endif

  always_comb begin
    state_n = state;
    ll_n    = lights_l;
    lr_n    = lights_r;
    last_n  = last_side;
    done_l  = 1'b0;
    done_r  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
`ifdef BLINK_HAZARD_EN
          if (req_hazard) begin
            state_n = HAZ;
            ll_n    = P3;
            lr_n    = P3;
          end else
`endif
          if (pend_l && (!pend_r || last_side == SIDE_RIGHT)) begin
            state_n = RUN_L;
            ll_n    = P1;
          end else if (pend_r) begin
            state_n = RUN_R;
            lr_n    = P1;
          end
        end
        RUN_L: begin
          ll_n = next_pattern(lights_l);
          if (lights_l == P3) begin
            state_n = IDLE;
            last_n  = SIDE_LEFT;
            done_l  = 1'b1;
          end
        end
        RUN_R: begin
          lr_n = next_pattern(lights_r);
          if (lights_r == P3) begin
            state_n = IDLE;
            last_n  = SIDE_RIGHT;
            done_r  = 1'b1;
          end
        end
`ifdef BLINK_HAZARD_EN
        HAZ: begin
          if (!req_hazard && lights_l == P0) begin
            state_n = IDLE;
          end else begin
            ll_n = ~lights_l;
            lr_n = ~lights_r;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          ll_n    = P0;
          lr_n    = P0;
        end
      endcase
    end
  end

  // A request seen while its own side runs is parked in again_x so the
  // completion tick re-arms pending instead of clearing it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lights_l  <= '0;
      lights_r  <= '0;
      busy      <= 1'b0;
      last_side <= SIDE_RIGHT;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      again_l   <= 1'b0;
      again_r   <= 1'b0;
    end else begin
      state     <= state_n;
      lights_l  <= ll_n;
      lights_r  <= lr_n;
      busy      <= (state_n != IDLE);
      last_side <= last_n;
      pend_l    <= done_l ? (again_l | req_left)  : (pend_l | req_left);
      pend_r    <= done_r ? (again_r | req_right) : (pend_r | req_right);
      again_l   <= (!done_l && state == RUN_L) ? (again_l | req_left)  : 1'b0;
      again_r   <= (!done_r && state == RUN_R) ? (again_r | req_right) : 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed self-checking bench for blink_scheduler at TICK_DIV = 2.
// Hazard scenario is selected by BLINK_HAZARD_EN, matching the RTL build.
module tb_blink_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_left = 1'b0;
  logic       req_right = 1'b0;
  logic       req_hazard = 1'b0;
  logic [2:0] lights_l, lights_r;
  logic       busy, last_side;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  blink_scheduler #(.TICK_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_left   (req_left),
    .req_right  (req_right),
    .req_hazard (req_hazard),
    .lights_l   (lights_l),
    .lights_r   (lights_r),
    .busy       (busy),
    .last_side  (last_side)
  );

  always #5 clk = ~clk;

  // Leaves the bench at negedge N0, right after reset is released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_left = 1'b0;
    req_right = 1'b0;
    req_hazard = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (lights_l !== 3'b000 || lights_r !== 3'b000 || busy !== 1'b0 || last_side !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got l=%b r=%b busy=%b last=%b, want 000 000 0 0",
               lights_l, lights_r, busy, last_side);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_left();
    logic [2:0] el;
    logic       eb;
    do_reset();
    req_left = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      el = (c < 2) ? 3'b000 : (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : (c < 8) ? 3'b111 : 3'b000;
      eb = (c >= 2 && c < 8);
      vectors++;
      if (lights_l !== el || lights_r !== 3'b000 || busy !== eb) begin
        miscompares++;
        $display("FAIL left_seq c=%0d: got l=%b r=%b busy=%b, want l=%b r=000 busy=%b",
                 c, lights_l, lights_r, busy, el, eb);
      end
      if (c == 1) req_left = 1'b0;
    end
    vectors++;
    if (last_side !== 1'b1) begin
      miscompares++;
      $display("FAIL left_last_side: got %b, want 1", last_side);
    end
  endtask

  task automatic test_both();
    logic [2:0] el, er;
    do_reset();
    req_left = 1'b1;
    req_right = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      el = (c < 2) ? 3'b000 : (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : (c < 8) ? 3'b111 : 3'b000;
      er = (c < 10) ? 3'b000 : (c < 12) ? 3'b001 : (c < 14) ? 3'b011 : (c < 16) ? 3'b111 : 3'b000;
      vectors++;
      if (lights_l !== el || lights_r !== er || (lights_l != 3'b000 && lights_r != 3'b000)) begin
        miscompares++;
        $display("FAIL both_rr c=%0d: got l=%b r=%b, want l=%b r=%b", c, lights_l, lights_r, el, er);
      end
      if (c == 1) begin
        req_left = 1'b0;
        req_right = 1'b0;
      end
    end
    vectors++;
    if (last_side !== 1'b0) begin
      miscompares++;
      $display("FAIL both_last_side: got %b, want 0", last_side);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] er;
    do_reset();
    req_right = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      er = (c < 2) ? 3'b000 : (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : (c < 8) ? 3'b111 :
           (c < 10) ? 3'b000 : (c < 12) ? 3'b001 : (c < 14) ? 3'b011 : (c < 16) ? 3'b111 : 3'b000;
      vectors++;
      if (lights_r !== er || lights_l !== 3'b000) begin
        miscompares++;
        $display("FAIL repeat_right c=%0d: got l=%b r=%b, want l=000 r=%b", c, lights_l, lights_r, er);
      end
      if (c == 1) req_right = 1'b0;
      if (c == 4) req_right = 1'b1;
      if (c == 5) req_right = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_right = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_right = 1'b0;
    end
    vectors++;
    if (lights_r !== 3'b011) begin
      miscompares++;
      $display("FAIL mid_precondition: got r=%b, want 011", lights_r);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (lights_l !== 3'b000 || lights_r !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got l=%b r=%b busy=%b, want 000 000 0", lights_l, lights_r, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vectors++;
      if (lights_l !== 3'b000 || lights_r !== 3'b000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_resume c=%0d: got l=%b r=%b busy=%b, want 000 000 0",
                 c, lights_l, lights_r, busy);
      end
    end
  endtask

`ifdef BLINK_HAZARD_EN
  task automatic test_hazard();
    logic [2:0] eh, el;
    logic       eb;
    do_reset();
    req_hazard = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 14) begin
        eh = (((c - 2) / 2) % 2 == 0) ? 3'b111 : 3'b000;
        el = eh;
      end else begin
        eh = 3'b000;
        el = (c < 16) ? 3'b000 : (c < 18) ? 3'b001 : (c < 20) ? 3'b011 : (c < 22) ? 3'b111 : 3'b000;
      end
      eb = (c >= 2 && c < 14) || (c >= 16 && c < 22);
      vectors++;
      if (lights_l !== el || lights_r !== eh || busy !== eb) begin
        miscompares++;
        $display("FAIL hazard c=%0d: got l=%b r=%b busy=%b, want l=%b r=%b busy=%b",
                 c, lights_l, lights_r, busy, el, eh, eb);
      end
      if (c == 3) req_left = 1'b1;
      if (c == 4) req_left = 1'b0;
      if (c == 12) req_hazard = 1'b0;
    end
  endtask
`else
  task automatic test_hazard();
    logic [2:0] el;
    do_reset();
    req_hazard = 1'b1;
    req_left = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      el = (c < 2) ? 3'b000 : (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : (c < 8) ? 3'b111 : 3'b000;
      vectors++;
      if (lights_l !== el || lights_r !== 3'b000) begin
        miscompares++;
        $display("FAIL hazard_ignored c=%0d: got l=%b r=%b, want l=%b r=000", c, lights_l, lights_r, el);
      end
      if (c == 1) req_left = 1'b0;
    end
    req_hazard = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_left();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
